// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester sequencer for single-port data memory (optional DMEM_ARB_FIXED_PRIO_EN = fixed priority)
module dmem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_we,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state;
  logic last_gnt, cur, win;
  // winner among pending requests (1 = requester 1)
`ifdef DMEM_ARB_FIXED_PRIO_EN
  always_comb win = !req0;
`else
  always_comb win = (req0 && req1) ? !last_gnt : req1;
`endif
  // FSM: latch winner in IDLE, execute the access for one cycle, return read data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      cur       <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
      mem_we    <= 1'b0;
      mem_waddr <= '0;
      mem_wdata <= '0;
      mem_raddr <= '0;
      busy      <= 1'b0;
    end else begin
      rvalid0 <= 1'b0;
      rvalid1 <= 1'b0;
      if (state == IDLE) begin
        if (req0 || req1) begin
          state     <= ACCESS;
          cur       <= win;
          gnt0      <= !win;
          gnt1      <= win;
          busy      <= 1'b1;
          mem_we    <= win ? we1 : we0;
          mem_waddr <= win ? addr1 : addr0;
          mem_raddr <= win ? addr1 : addr0;
          mem_wdata <= win ? wdata1 : wdata0;
        end
      end else begin
        state    <= IDLE;
        gnt0     <= 1'b0;
        gnt1     <= 1'b0;
        busy     <= 1'b0;
        mem_we   <= 1'b0;
        last_gnt <= cur;
        if (!mem_we && !cur) begin
          rvalid0 <= 1'b1;
          rdata0  <= mem_rdata;
        end
        if (!mem_we && cur) begin
          rvalid1 <= 1'b1;
          rdata1  <= mem_rdata;
        end
      end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a transaction-level model
module tb_dmem_arbiter;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 1'b0, rst_n = 1'b0;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we, busy;
  logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_waddr, mem_raddr;
  logic [DW-1:0] tmem [32] = '{default: '0};
  logic [DW-1:0] ref_mem [32] = '{default: '0};
  int checks = 0, failures = 0;
  logic e_gnt0, e_gnt1, e_busy, e_we, e_rv0, e_rv1, e_id, last;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wd, e_rd0, e_rd1;
  logic p0, p1;
  int seq [$];

  always #5 clk = ~clk;
  assign mem_rdata = tmem[mem_raddr];
  always @(posedge clk) if (mem_we) tmem[mem_waddr] <= mem_wdata;

  dmem_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1), .mem_we(mem_we), .mem_waddr(mem_waddr),
    .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    {e_gnt0, e_gnt1, e_busy, e_we, e_rv0, e_rv1, e_id} = '0;
    e_addr = '0;
    e_wd = '0;
    e_rd0 = '0;
    e_rd1 = '0;
    last = 1'b1;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".gnt0"}, DW'(gnt0), DW'(e_gnt0));
    chk({tag, ".gnt1"}, DW'(gnt1), DW'(e_gnt1));
    chk({tag, ".busy"}, DW'(busy), DW'(e_busy));
    chk({tag, ".mem_we"}, DW'(mem_we), DW'(e_we));
    chk({tag, ".mem_waddr"}, DW'(mem_waddr), DW'(e_addr));
    chk({tag, ".mem_raddr"}, DW'(mem_raddr), DW'(e_addr));
    chk({tag, ".mem_wdata"}, mem_wdata, e_wd);
    chk({tag, ".rvalid0"}, DW'(rvalid0), DW'(e_rv0));
    chk({tag, ".rvalid1"}, DW'(rvalid1), DW'(e_rv1));
    chk({tag, ".rdata0"}, rdata0, e_rd0);
    chk({tag, ".rdata1"}, rdata1, e_rd1);
  endtask

  // one clock: the model consumes the requests seen at the edge, outputs are checked mid-cycle
  task automatic cyc(input string tag);
    logic w;
    @(posedge clk);
    e_rv0 = 1'b0;
    e_rv1 = 1'b0;
    if (e_busy) begin
      if (e_we) ref_mem[e_addr] = e_wd;
      else if (e_id) begin e_rv1 = 1'b1; e_rd1 = ref_mem[e_addr]; end
      else begin e_rv0 = 1'b1; e_rd0 = ref_mem[e_addr]; end
      last = e_id;
      {e_busy, e_gnt0, e_gnt1, e_we} = '0;
    end else if (req0 || req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
      w = !req0;
`else
      w = !req0 ? 1'b1 : !req1 ? 1'b0 : !last;
`endif
      e_id = w;
      e_busy = 1'b1;
      e_gnt0 = !w;
      e_gnt1 = w;
      e_we = w ? we1 : we0;
      e_addr = w ? addr1 : addr0;
      e_wd = w ? wdata1 : wdata0;
    end
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    // single write
    req0 = 1; we0 = 1; addr0 = 3; wdata0 = 32'hDEADBEEF;
    cyc("wr");
    chk("wr_gnt0", DW'(gnt0), 1);
    chk("wr_mem_we", DW'(mem_we), 1);
    req0 = 0;
    cyc("wr_done");
    chk("wr_mem3", tmem[3], 32'hDEADBEEF);
    // read-back through requester 1
    req1 = 1; we1 = 0; addr1 = 3;
    cyc("rd");
    chk("rd_gnt1", DW'(gnt1), 1);
    req1 = 0;
    cyc("rd_resp");
    chk("rd_rvalid1", DW'(rvalid1), 1);
    chk("rd_rdata1", rdata1, 32'hDEADBEEF);
    chk("rd_rvalid0", DW'(rvalid0), 0);
    // continuous contention
    req0 = 1; we0 = 0; addr0 = 1; req1 = 1; we1 = 0; addr1 = 2;
    for (int i = 0; i < 8; i++) begin
      cyc("cont");
      if (gnt0) seq.push_back(0);
      if (gnt1) seq.push_back(1);
    end
    req0 = 0; req1 = 0;
    cyc("cont_drain");
    chk("cont_count", DW'(seq.size()), 4);
    for (int i = 0; i < seq.size(); i++)
`ifdef DMEM_ARB_FIXED_PRIO_EN
      chk($sformatf("cont_seq%0d", i), DW'(seq[i]), 0);
`else
      chk($sformatf("cont_seq%0d", i), DW'(seq[i]), DW'(i % 2));
`endif
    // reset during a write access
    req0 = 1; we0 = 1; addr0 = 7; wdata0 = 32'h55;
    cyc("rst_wr");
    req0 = 0;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_mem_we", DW'(mem_we), 0);
    check_all("rst_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mem7", tmem[7], 32'h0);
    for (int i = 0; i < 10; i++) cyc("idle");
    // first tie after reset goes to requester 0
    req0 = 1; we0 = 0; addr0 = 3; req1 = 1; we1 = 0; addr1 = 7;
    cyc("tie");
    chk("tie_gnt0", DW'(gnt0), 1);
    req0 = 0; req1 = 0;
    cyc("tie_resp");
    // random traffic with protocol-abiding requesters
    p0 = 0; p1 = 0;
    for (int i = 0; i < 400; i++) begin
      if (e_gnt0) p0 = 0;
      if (e_gnt1) p1 = 0;
      if (!p0 && $urandom_range(2) == 0) begin
        p0 = 1; we0 = $urandom_range(1); addr0 = AW'($urandom_range(7)); wdata0 = $urandom;
      end
      if (!p1 && $urandom_range(2) == 0) begin
        p1 = 1; we1 = $urandom_range(1); addr1 = AW'($urandom_range(7)); wdata1 = $urandom;
      end
      req0 = p0;
      req1 = p1;
      cyc("rand");
    end
    req0 = 0; req1 = 0;
    repeat (3) cyc("rand_drain");
    for (int i = 0; i < 32; i++) chk($sformatf("mem%0d", i), tmem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
